radio_frame_serializer: RTL and testbench
=========================================

# radio_frame_serializer

Parametrised successor to the two-radio sample serialiser. It clocks NUM_RADIOS front-ends from a divided system clock and captures their I/Q samples once per sample period. Captured samples are buffered in a small FIFO and shifted out as back-to-back framed bit streams on a single serial line, with a frame-start strobe. It sits between the radio front-ends and the downstream correlator/uC link. It replaces the fixed 2-radio, 2-bit, unbuffered path.

## Interface
- NUM_RADIOS, 2, number of radio channels (≥1)
- SAMPLE_BITS, 2, bits per I and per Q sample (≥1)
- CLK_DIV, 8, SYS_CLK cycles per radio sample period (even, ≥2)
- FIFO_DEPTH, 4, captured-frame buffer depth (power of 2, ≥2)

Ports:
- SYS_CLK  in  1  system clock; all logic on rising edge
- RST_N  in  1  synchronous active-low reset
- ENABLE  in  1  capture enable
- R_I  in  NUM_RADIOS*SAMPLE_BITS  I samples; radio r at bits [r*SAMPLE_BITS +: SAMPLE_BITS]
- R_Q  in  NUM_RADIOS*SAMPLE_BITS  Q samples, same packing
- CLK_OUT  out  1  radio sample clock, 50% duty, period CLK_DIV
- DATA_OUT  out  1  serial frame data, registered
- SYNC  out  1  high during the first bit of each frame, registered
- OVERFLOW  out  1  sticky: a capture was dropped because the FIFO was full

## Operation
- Divider counter cnt runs 0..CLK_DIV-1 and wraps. CLK_OUT=1 for cnt<CLK_DIV/2, else 0. The divider runs regardless of ENABLE.
- Capture edge: cnt==CLK_DIV-1 with ENABLE=1. The frame word is pushed to the FIFO.
- Frame order, MSB first: for r=NUM_RADIOS-1 down to 0, I[r] MSB..LSB then Q[r] MSB..LSB. FRAME_BITS = 2*NUM_RADIOS*SAMPLE_BITS (+1 with parity).
- FIFO full at a capture edge:
  - With no pop in the same cycle, the sample is dropped and OVERFLOW is set.
  - With a simultaneous pop, the push is accepted and the count is unchanged.
- Serializer FSM:
  - IDLE: DATA_OUT=0, SYNC=0. If the FIFO is not empty, pop into the shift register, go to SHIFT, bit index 0.
  - SHIFT: DATA_OUT=current bit. SYNC=1 only at index 0. Index increments each cycle.
  - At index FRAME_BITS-1: if the FIFO is not empty, pop and restart at index 0 with no gap cycle. Otherwise return to IDLE.
- ENABLE=0:
  - No new captures.
  - The frame in flight and the buffered frames still drain.
  - OVERFLOW clears.
- Throughput is sustained iff FRAME_BITS ≤ CLK_DIV. Otherwise the FIFO fills and OVERFLOW follows.

## Timing
- Reset values, all outputs: CLK_OUT=0, DATA_OUT=0, SYNC=0, OVERFLOW=0.
- Reset internal state: cnt=0, FIFO empty, FSM=IDLE.
- The first CLK_OUT rising edge comes on the first cycle after RST_N deasserts, when cnt goes 0 → registered high.
- Latency with an empty FIFO and IDLE FSM:
  - Capture at edge E writes the FIFO at E.
  - Pop at E+1.
  - First bit and SYNC=1 are visible after edge E+2.
- Successive frames are contiguous; SYNC is high once per FRAME_BITS cycles.
- Reset asserted mid-frame: the partial frame is abandoned and all state returns to reset values at that edge. No trailing bits are emitted.
- OVERFLOW is set on the edge of the dropped capture.

## Configuration
- RADIO_FRAME_PARITY_EN defined:
  - One even-parity bit is appended after the last Q bit of each frame.
  - The parity bit is the XOR of all data bits.
  - FRAME_BITS grows by 1, and so does the sustainable-throughput bound.
- RADIO_FRAME_PARITY_EN undefined: no parity bit; frames are data bits only.

## Test plan
- Defaults, ENABLE=1, R_I=4'b1000, R_Q=4'b1101 (R1_I=10, R1_Q=11, R0_I=00, R0_Q=01) -> DATA_OUT repeats 1,0,1,1,0,0,0,1 with SYNC on the first 1, one frame per 8 cycles, no gaps, OVERFLOW=0.
- Same stimulus with RADIO_FRAME_PARITY_EN and CLK_DIV=10 -> 9-bit frames 1,0,1,1,0,0,0,1,0. Parity 0 (four ones).
- Reset release -> CLK_OUT period 8 (4 high, 4 low). First SYNC appears 2 cycles after the first cnt==7 edge.
- CLK_DIV=4, FIFO_DEPTH=4, 8-bit frames -> OVERFLOW rises before cycle 48. DATA_OUT stays gapless with SYNC every 8 cycles. ENABLE low then clears OVERFLOW, and the remaining buffered frames drain.
- ENABLE deasserted mid-frame -> the current frame and buffered frames complete, then DATA_OUT=0 and SYNC=0 in IDLE. CLK_OUT keeps toggling.
- RST_N low at bit index 3 -> DATA_OUT=0 and SYNC=0 on the next edge. After release, the first frame starts fresh with SYNC.

Source files
------------

// File: rtl/radio_frame_serializer.sv
// radio_frame_serializer: divided radio clock, per-period I/Q capture, FIFO-buffered framed serial output.
// Define RADIO_FRAME_PARITY_EN to append an even-parity bit to every frame.
module radio_frame_serializer #(
  parameter int NUM_RADIOS  = 2,
  parameter int SAMPLE_BITS = 2,
  parameter int CLK_DIV     = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              SYS_CLK,
  input  logic                              RST_N,
  input  logic                              ENABLE,
  input  logic [NUM_RADIOS*SAMPLE_BITS-1:0] R_I,
  input  logic [NUM_RADIOS*SAMPLE_BITS-1:0] R_Q,
  output logic                              CLK_OUT,
  output logic                              DATA_OUT,
  output logic                              SYNC,
  output logic                              OVERFLOW
);
  localparam int DATA_BITS = 2*NUM_RADIOS*SAMPLE_BITS;
`ifdef RADIO_FRAME_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 1;
`else
  localparam int FRAME_BITS = DATA_BITS;
`endif
  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(FRAME_BITS);
  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;
  logic [CW-1:0] cnt;
  logic [DATA_BITS-1:0] data;
  logic [FRAME_BITS-1:0] frame;
  logic [FRAME_BITS-1:0] mem [FIFO_DEPTH];
  logic [FRAME_BITS-1:0] sh;
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] level;
  logic [IW-1:0] idx;
  logic state, cap, full, empty, last, pop, push;
  // highest radio lands in the top bits so the frame shifts out MSB first
  for (genvar r = 0; r < NUM_RADIOS; r++) begin : g_pack
    assign data[2*SAMPLE_BITS*r +: 2*SAMPLE_BITS] = {R_I[r*SAMPLE_BITS +: SAMPLE_BITS], R_Q[r*SAMPLE_BITS +: SAMPLE_BITS]};
  end
`ifdef RADIO_FRAME_PARITY_EN
  assign frame = {data, ^data};
`else
  assign frame = data;
`endif
  assign cap   = ENABLE && cnt == CW'(CLK_DIV - 1);
  assign full  = level == LW'(FIFO_DEPTH);
  assign empty = level == '0;
  assign last  = idx == IW'(FRAME_BITS - 1);
  assign pop   = !empty && (state == IDLE || last);
  assign push  = cap && (!full || pop);
  always_ff @(posedge SYS_CLK) begin
    if (!RST_N) begin
      cnt      <= '0;
      CLK_OUT  <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      state    <= IDLE;
      idx      <= '0;
      sh       <= '0;
      DATA_OUT <= 1'b0;
      SYNC     <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      cnt      <= cnt == CW'(CLK_DIV - 1) ? '0 : cnt + 1'b1;
      CLK_OUT  <= cnt < CW'(CLK_DIV / 2);
      if (push) begin
        mem[wp] <= frame;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      level    <= level + LW'(push) - LW'(pop);
      OVERFLOW <= ENABLE && (OVERFLOW || (cap && !push));
      DATA_OUT <= state == SHIFT && sh[FRAME_BITS-1];
      SYNC     <= state == SHIFT && idx == '0;
      if (pop) begin
        sh    <= mem[rp];
        idx   <= '0;
        state <= SHIFT;
      end else if (state == SHIFT) begin
        state <= last ? IDLE : SHIFT;
        sh    <= sh << 1;
        idx   <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_radio_frame_serializer.sv
// tb_radio_frame_serializer: timestamp-based reference model of two serializer instances (sustained and overloaded).
module tb_radio_frame_serializer;
  localparam int NR = 2, SB = 2, W = NR*SB, DB = 2*W;
`ifdef RADIO_FRAME_PARITY_EN
  localparam int FB = DB + 1;
  localparam int CD0 = 10;
  localparam logic [FB-1:0] LIT = 9'b101100010;
`else
  localparam int FB = DB;
  localparam int CD0 = 8;
  localparam logic [FB-1:0] LIT = 8'b10110001;
`endif
  localparam int CD1 = 4, DEPTH = 4;
  typedef struct { int k; int push; int start; logic [FB-1:0] bits; } fr_t;
  logic clk = 0, rst_n = 0, en = 0;
  logic [W-1:0] ri = '0, rq = '0;
  logic [1:0] co, dout, sy, ov;
  logic e_co [2], e_do [2], e_sy [2], e_ov [2];
  int t [2], last_start [2], cdv [2];
  fr_t fq [$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  radio_frame_serializer #(.NUM_RADIOS(NR), .SAMPLE_BITS(SB), .CLK_DIV(CD0), .FIFO_DEPTH(DEPTH)) u0 (
    .SYS_CLK(clk), .RST_N(rst_n), .ENABLE(en), .R_I(ri), .R_Q(rq),
    .CLK_OUT(co[0]), .DATA_OUT(dout[0]), .SYNC(sy[0]), .OVERFLOW(ov[0]));
  radio_frame_serializer #(.NUM_RADIOS(NR), .SAMPLE_BITS(SB), .CLK_DIV(CD1), .FIFO_DEPTH(DEPTH)) u1 (
    .SYS_CLK(clk), .RST_N(rst_n), .ENABLE(en), .R_I(ri), .R_Q(rq),
    .CLK_OUT(co[1]), .DATA_OUT(dout[1]), .SYNC(sy[1]), .OVERFLOW(ov[1]));
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, e);
    end
  endtask
  // frame bits in transmission order: radio NR-1 first, I MSB..LSB then Q MSB..LSB
  function automatic logic [FB-1:0] frame_of(input logic [W-1:0] i, input logic [W-1:0] q);
    logic [FB-1:0] f = '0;
    int n = FB - 1;
    logic p = 1'b0;
    for (int r = NR - 1; r >= 0; r--) begin
      for (int b = SB - 1; b >= 0; b--) begin f[n] = i[r*SB+b]; p ^= i[r*SB+b]; n--; end
      for (int b = SB - 1; b >= 0; b--) begin f[n] = q[r*SB+b]; p ^= q[r*SB+b]; n--; end
    end
`ifdef RADIO_FRAME_PARITY_EN
    f[0] = p;
`endif
    return f;
  endfunction
  // each accepted frame gets a start time: two edges after capture, or right after the previous frame
  task automatic model_step();
    int occ, st;
    bit popnow, cap, drop;
    fr_t f;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int j = fq.size() - 1; j >= 0; j--) if (fq[j].k == k) fq.delete(j);
        t[k] = 0; last_start[k] = -1000;
        e_co[k] = 0; e_do[k] = 0; e_sy[k] = 0; e_ov[k] = 0;
      end else begin
        occ = 0; popnow = 0;
        cap = en && (t[k] % cdv[k] == cdv[k] - 1);
        foreach (fq[j]) if (fq[j].k == k) begin
          if (fq[j].push < t[k] && fq[j].start - 1 >= t[k]) occ++;
          if (fq[j].start - 1 == t[k]) popnow = 1;
        end
        drop = cap && occ == DEPTH && !popnow;
        if (cap && !drop) begin
          st = (t[k] + 2 > last_start[k] + FB) ? t[k] + 2 : last_start[k] + FB;
          f.k = k; f.push = t[k]; f.start = st; f.bits = frame_of(ri, rq);
          fq.push_back(f);
          last_start[k] = st;
        end
        e_co[k] = (t[k] % cdv[k]) < cdv[k] / 2;
        e_do[k] = 0; e_sy[k] = 0;
        foreach (fq[j]) if (fq[j].k == k && fq[j].start <= t[k] && t[k] < fq[j].start + FB) begin
          e_do[k] = fq[j].bits[FB-1-(t[k]-fq[j].start)];
          e_sy[k] = t[k] == fq[j].start;
        end
        e_ov[k] = en && (e_ov[k] || drop);
        t[k]++;
        for (int j = fq.size() - 1; j >= 0; j--) if (fq[j].k == k && fq[j].start + FB <= t[k]) fq.delete(j);
      end
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("clk_out%0d", k), 32'(co[k]), 32'(e_co[k]));
      chk($sformatf("data_out%0d", k), 32'(dout[k]), 32'(e_do[k]));
      chk($sformatf("sync%0d", k), 32'(sy[k]), 32'(e_sy[k]));
      chk($sformatf("overflow%0d", k), 32'(ov[k]), 32'(e_ov[k]));
    end
  endtask
  initial begin
    int fs, hc, got;
    logic [2*FB-1:0] frm;
    cdv[0] = CD0; cdv[1] = CD1;
    ri = 4'b1000; rq = 4'b1101;
    chk("model_frame", 32'(frame_of(ri, rq)), 32'(LIT));
    repeat (3) cycle();
    chk("rst_outputs", {28'd0, co[0], dout[0], sy[0], ov[0]}, 32'd0);
    rst_n = 1; en = 1;
    fs = -1; hc = 0; frm = '0;
    for (int e = 0; e < 60; e++) begin
      cycle();
      if (e == 0) chk("first_clk_out_high", 32'(co[0]), 32'd1);
      if (e < CD0) hc += int'(co[0]);
      if (fs < 0 && sy[0]) fs = e;
      if (fs >= 0 && e - fs < 2*FB) frm = {frm[2*FB-2:0], dout[0]};
      if (e == 47) chk("overload_overflow", 32'(ov[1]), 32'd1);
      if (e == 47) chk("sustained_no_overflow", 32'(ov[0]), 32'd0);
    end
    chk("clk_out_high_cycles", 32'(hc), 32'(CD0/2));
    chk("first_sync_edge", 32'(fs), 32'(CD0 + 1));
    chk("two_frames_gapless", 32'(frm), 32'({LIT, LIT}));
    en = 0;
    repeat (60) cycle();
    chk("drained_idle", {29'd0, dout[1], sy[1], ov[1]}, 32'd0);
    chk("drained_idle0", {30'd0, dout[0], sy[0]}, 32'd0);
    en = 1; got = 0;
    for (int e = 0; e < 4*CD0 && !got; e++) begin
      cycle();
      if (sy[0]) got = 1;
    end
    chk("sync_before_reset", 32'(got), 32'd1);
    repeat (3) cycle();
    rst_n = 0;
    cycle();
    chk("midframe_reset", {30'd0, dout[0], sy[0]}, 32'd0);
    rst_n = 1;
    for (int e = 0; e < 3000; e++) begin
      ri = W'($urandom); rq = W'($urandom);
      if ($urandom_range(0, 49) == 0) en = ~en;
      rst_n = $urandom_range(0, 399) != 0;
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
